vec_alu_issue: RTL and testbench

- Issue stage directly upstream of the 8-lane vector ALU block.
- Buffers vector operation requests (two operand vectors, 3-bit opcode, destination tag) in a small FIFO.
- Presents one operation per cycle to the ALU.
- Tracks the ALU's capture-at-posedge / result-at-negedge timing so each result returns on a writeback port with its tag.
- Decouples the instruction/decode side (valid/ready) from the fixed-latency ALU.

---
 rtl/vec_alu_pkg.sv | 34 +++
 rtl/vec_issue_fifo.sv | 72 +++++++
 rtl/vec_alu_issue.sv | 119 +++++++++++
 tb/tb_vec_alu_issue.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_alu_pkg.sv
// Shared types and constants for the vector ALU issue stage.
// An issue entry bundles both operand vectors, the ALU opcode and the destination tag.
package vec_alu_pkg;

    localparam int ELEMENT_SIZE = 8;
    localparam int VECTOR_SIZE  = 8;
    localparam int VW           = ELEMENT_SIZE * VECTOR_SIZE;
    localparam int TAG_W        = 4;

    localparam logic [2:0] OP_0    = 3'b000;
    localparam logic [2:0] OP_1    = 3'b001;
    localparam logic [2:0] OP_2    = 3'b010;
    localparam logic [2:0] OP_3    = 3'b011;
    localparam logic [2:0] OP_4    = 3'b100;
    localparam logic [2:0] OP_5    = 3'b101;
    localparam logic [2:0] OP_LAST = 3'b101;

    typedef logic [VW-1:0] vec_t;

    typedef struct packed {
        vec_t             oper1;
        vec_t             oper2;
        logic [2:0]       opCode;
        logic [TAG_W-1:0] tag;
    } issue_entry_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        case (op)
            OP_0, OP_1, OP_2, OP_3, OP_4, OP_5: is_legal_op = 1'b1;
            default:                            is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vec_issue_fifo.sv
// Synchronous FIFO of issue entries with a combinational head, flush and an
// occupancy counter one bit wider than the pointers so full and empty differ.
module vec_issue_fifo
    import vec_alu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  issue_entry_t i_data,
    input  logic         i_pop,
    output issue_entry_t o_data,
    output logic         o_full,
    output logic         o_empty,
    output logic [AW:0]  o_occupancy
);

    issue_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full      = (r_count == (AW+1)'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_occupancy = r_count;
    assign o_data      = r_mem[r_rd_ptr];

    // A flush wins over any push or pop in the same cycle.
    assign w_do_push = i_push & ~o_full & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (w_do_push && (r_wr_ptr == AW'(gi))) begin
                    r_mem[gi] <= i_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vec_alu_issue.sv
// Issue stage in front of the 8-lane vector ALU: queues requests, issues one per
// cycle, and returns each negedge-updated ALU result with its tag two cycles later.
module vec_alu_issue
    import vec_alu_pkg::issue_entry_t;
    import vec_alu_pkg::is_legal_op;
    import vec_alu_pkg::OP_0;
#(
    parameter int ELEMENT_SIZE = vec_alu_pkg::ELEMENT_SIZE,
    parameter int VECTOR_SIZE  = vec_alu_pkg::VECTOR_SIZE,
    parameter int DEPTH        = 4,
    parameter int TAG_W        = vec_alu_pkg::TAG_W,
    localparam int VW = ELEMENT_SIZE * VECTOR_SIZE,
    localparam int OW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             inValid,
    output logic             inReady,
    input  logic [VW-1:0]    inOper1,
    input  logic [VW-1:0]    inOper2,
    input  logic [2:0]       inOpCode,
    input  logic [TAG_W-1:0] inTag,
    output logic [VW-1:0]    aluOper1,
    output logic [VW-1:0]    aluOper2,
    output logic [2:0]       aluOpCode,
    input  logic [VW-1:0]    aluResult,
    output logic             wbValid,
    output logic [TAG_W-1:0] wbTag,
    output logic [VW-1:0]    wbData,
    output logic             illegalOp,
    output logic [OW-1:0]    occupancy
);

    issue_entry_t     w_push_entry;
    issue_entry_t     w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_legal;
    logic             w_push;

    logic             r_if_valid;
    logic [TAG_W-1:0] r_if_tag;
    logic             r_wb_valid;
    logic [TAG_W-1:0] r_wb_tag;
    logic [VW-1:0]    r_wb_data;
    logic             r_illegal_op;

    // Ready comes from the registered count only, so a pop never frees a full slot early.
    assign inReady  = ~w_full;
    assign w_accept = inValid & ~w_full;
    assign w_legal  = is_legal_op(inOpCode);
    assign w_push   = w_accept & w_legal;

    always_comb begin
        w_push_entry        = '0;
        w_push_entry.oper1  = inOper1;
        w_push_entry.oper2  = inOper2;
        w_push_entry.opCode = inOpCode;
        w_push_entry.tag    = inTag;
    end

    vec_issue_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (flush),
        .i_push     (w_push),
        .i_data     (w_push_entry),
        .i_pop      (~w_empty),
        .o_data     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_occupancy(occupancy)
    );

    always_comb begin
        aluOper1  = '0;
        aluOper2  = '0;
        aluOpCode = OP_0;
        if (!w_empty) begin
            aluOper1  = w_head.oper1;
            aluOper2  = w_head.oper2;
            aluOpCode = w_head.opCode;
        end
    end

    // The ALU result for the op in flight settles at the negedge, so it is
    // captured at the following posedge together with that op's tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_valid   <= 1'b0;
            r_if_tag     <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_tag     <= '0;
            r_wb_data    <= '0;
            r_illegal_op <= 1'b0;
        end else begin
            r_illegal_op <= w_accept & ~w_legal;
            r_if_valid   <= ~w_empty & ~flush;
            if (!w_empty) begin
                r_if_tag <= w_head.tag;
            end
            r_wb_valid <= r_if_valid & ~flush;
            if (r_if_valid && !flush) begin
                r_wb_tag  <= r_if_tag;
                r_wb_data <= aluResult;
            end
        end
    end

    assign wbValid   = r_wb_valid;
    assign wbTag     = r_wb_tag;
    assign wbData    = r_wb_data;
    assign illegalOp = r_illegal_op;

endmodule

// File: tb/tb_vec_alu_issue.sv
// Randomised and directed bench for vec_alu_issue with a negedge-updating ALU stub
// and a cycle-level queue model of issue, writeback, occupancy and illegal pulses.
module tb_vec_alu_issue;

    localparam int DEPTH = 4;
    localparam int VW    = 64;
    localparam int TW    = 4;
    localparam int OW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          inValid;
    logic          inReady;
    logic [VW-1:0] inOper1;
    logic [VW-1:0] inOper2;
    logic [2:0]    inOpCode;
    logic [TW-1:0] inTag;
    logic [VW-1:0] aluOper1;
    logic [VW-1:0] aluOper2;
    logic [2:0]    aluOpCode;
    logic [VW-1:0] aluResult = '0;
    logic          wbValid;
    logic [TW-1:0] wbTag;
    logic [VW-1:0] wbData;
    logic          illegalOp;
    logic [OW-1:0] occupancy;

    int n_cmp  = 0;
    int n_fail = 0;

    vec_alu_issue #(
        .ELEMENT_SIZE(8),
        .VECTOR_SIZE (8),
        .DEPTH       (DEPTH),
        .TAG_W       (TW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .inValid  (inValid),
        .inReady  (inReady),
        .inOper1  (inOper1),
        .inOper2  (inOper2),
        .inOpCode (inOpCode),
        .inTag    (inTag),
        .aluOper1 (aluOper1),
        .aluOper2 (aluOper2),
        .aluOpCode(aluOpCode),
        .aluResult(aluResult),
        .wbValid  (wbValid),
        .wbTag    (wbTag),
        .wbData   (wbData),
        .illegalOp(illegalOp),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Stand-in ALU arithmetic; any distinct function of the operands serves.
    function automatic logic [VW-1:0] alu_f(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd0:    alu_f = a + b;
            3'd1:    alu_f = a - b;
            3'd2:    alu_f = a & b;
            3'd3:    alu_f = a | b;
            3'd4:    alu_f = a ^ b;
            default: alu_f = ~a;
        endcase
    endfunction

    // ALU stub: operands seen during cycle N give a result at the negedge inside N+1.
    logic [VW-1:0] s_o1 = '0;
    logic [VW-1:0] s_o2 = '0;
    logic [2:0]    s_op = '0;
    always @(negedge clk) begin
        aluResult <= alu_f(s_o1, s_o2, s_op);
        s_o1      <= aluOper1;
        s_o2      <= aluOper2;
        s_op      <= aluOpCode;
    end

    typedef struct {
        int            push;
        int            issue;
        int            wb;
        logic [TW-1:0] tag;
        logic [VW-1:0] o1;
        logic [VW-1:0] o2;
        logic [2:0]    opc;
    } ent_t;

    ent_t q[$];
    int   cyc = 0;
    int   illegal_cyc = -10;
    logic exp_ready;
    int   exp_occ;
    logic [TW-1:0]       exp_wbt = '0;
    logic [VW-1:0]       exp_wbd = '0;
    logic [TW+VW:0]      wb_exp;
    logic [2*VW+2:0]     alu_exp;
    logic [OW+1:0]       ctl_exp;

    task automatic model_clear();
        q.delete();
        exp_wbt     = '0;
        exp_wbd     = '0;
        illegal_cyc = -10;
    endtask

    // Apply inputs for the current cycle, then at the negedge compute what the
    // outputs must be from the queue model.
    task automatic drive(input logic v, input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input logic [2:0] op, input logic [TW-1:0] t, input logic fl);
        logic          wbv;
        logic [VW-1:0] a1;
        logic [VW-1:0] a2;
        logic [2:0]    aop;
        inValid  = v;
        inOper1  = a;
        inOper2  = b;
        inOpCode = op;
        inTag    = t;
        flush    = fl;
        @(negedge clk);
        exp_occ = 0;
        wbv     = 1'b0;
        a1      = '0;
        a2      = '0;
        aop     = 3'b000;
        foreach (q[i]) begin
            if (q[i].push < cyc && q[i].issue >= cyc) exp_occ++;
            if (q[i].issue == cyc) begin
                a1  = q[i].o1;
                a2  = q[i].o2;
                aop = q[i].opc;
            end
            if (q[i].wb == cyc) begin
                wbv     = 1'b1;
                exp_wbt = q[i].tag;
                exp_wbd = alu_f(q[i].o1, q[i].o2, q[i].opc);
            end
        end
        exp_ready = (exp_occ < DEPTH);
        wb_exp    = {wbv, exp_wbt, exp_wbd};
        alu_exp   = {a1, a2, aop};
        ctl_exp   = {exp_ready, OW'(exp_occ), (illegal_cyc == cyc - 1)};
    endtask

    // Commit this cycle's handshake into the model and move to the next cycle.
    task automatic advance();
        ent_t e;
        int   last;
        if (flush) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].wb > cyc) q.delete(i);
            end
        end
        if (inValid && exp_ready) begin
            if (inOpCode > 3'd5) begin
                illegal_cyc = cyc;
            end else if (!flush) begin
                last    = (q.size() > 0) ? q[q.size()-1].issue : cyc;
                e.push  = cyc;
                e.issue = (last + 1 > cyc + 1) ? last + 1 : cyc + 1;
                e.wb    = e.issue + 2;
                e.tag   = inTag;
                e.o1    = inOper1;
                e.o2    = inOper2;
                e.opc   = inOpCode;
                q.push_back(e);
            end
        end
        while (q.size() > 0 && q[0].wb < cyc) void'(q.pop_front());
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 3'b000, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (wbValid !== 1'b0)   begin n_fail++; $display("FAIL reset_wbValid: got %b want 0", wbValid); end
        n_cmp++; if (wbTag !== '0)       begin n_fail++; $display("FAIL reset_wbTag: got %h want 0", wbTag); end
        n_cmp++; if (wbData !== '0)      begin n_fail++; $display("FAIL reset_wbData: got %h want 0", wbData); end
        n_cmp++; if (illegalOp !== 1'b0) begin n_fail++; $display("FAIL reset_illegalOp: got %b want 0", illegalOp); end
        n_cmp++; if (occupancy !== '0)   begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        n_cmp++; if (inReady !== 1'b1)   begin n_fail++; $display("FAIL reset_inReady: got %b want 1", inReady); end
        n_cmp++; if ({aluOper1, aluOper2, aluOpCode} !== '0) begin
            n_fail++; $display("FAIL reset_alu: got %h %h %b want zeros", aluOper1, aluOper2, aluOpCode);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        model_clear();
    endtask

    task automatic test_single();
        for (int k = 0; k < 6; k++) begin
            if (k == 0) drive(1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h1122334455667788, 3'b000, 4'd3, 1'b0);
            else        drive(1'b0, '0, '0, 3'b000, '0, 1'b0);
            n_cmp++; if (wbValid !== (k == 3)) begin n_fail++; $display("FAIL single_latency k=%0d: got wbValid=%b", k, wbValid); end
            n_cmp++; if ({wbValid, wbTag, wbData} !== wb_exp) begin
                n_fail++; $display("FAIL single_wb k=%0d: got %b/%h/%h want %h", k, wbValid, wbTag, wbData, wb_exp);
            end
            n_cmp++; if ({aluOper1, aluOper2, aluOpCode} !== alu_exp) begin
                n_fail++; $display("FAIL single_alu k=%0d: got %h %h %b want %h", k, aluOper1, aluOper2, aluOpCode, alu_exp);
            end
            n_cmp++; if ({inReady, occupancy, illegalOp} !== ctl_exp) begin
                n_fail++; $display("FAIL single_ctl k=%0d: got %b want %b", k, {inReady, occupancy, illegalOp}, ctl_exp);
            end
            if (wbValid) $display("single: wb tag=%0d data=%h", wbTag, wbData);
            advance();
        end
    endtask

    task automatic test_back_to_back();
        int n_wb = 0;
        for (int k = 0; k < 10; k++) begin
            if (k < 6) drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 3'(k), TW'(k), 1'b0);
            else       drive(1'b0, '0, '0, 3'b000, '0, 1'b0);
            n_cmp++; if ({wbValid, wbTag, wbData} !== wb_exp) begin
                n_fail++; $display("FAIL b2b_wb k=%0d: got %b/%h/%h want %h", k, wbValid, wbTag, wbData, wb_exp);
            end
            n_cmp++; if ({aluOper1, aluOper2, aluOpCode} !== alu_exp) begin
                n_fail++; $display("FAIL b2b_alu k=%0d: got %b want %h", k, aluOpCode, alu_exp);
            end
            n_cmp++; if ({inReady, occupancy, illegalOp} !== ctl_exp) begin
                n_fail++; $display("FAIL b2b_ctl k=%0d: got %b want %b", k, {inReady, occupancy, illegalOp}, ctl_exp);
            end
            if (wbValid) begin
                n_wb++;
                $display("b2b: wb tag=%0d data=%h", wbTag, wbData);
            end
            advance();
        end
        n_cmp++; if (n_wb !== 6) begin n_fail++; $display("FAIL b2b_count: got %0d pulses want 6", n_wb); end
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 5; k++) begin
            if (k == 0) drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 3'b110, 4'd7, 1'b0);
            else        drive(1'b0, '0, '0, 3'b000, '0, 1'b0);
            n_cmp++; if (illegalOp !== (k == 1)) begin n_fail++; $display("FAIL illegal_pulse k=%0d: got %b", k, illegalOp); end
            n_cmp++; if (wbValid !== 1'b0 || occupancy !== '0) begin
                n_fail++; $display("FAIL illegal_stored k=%0d: got wbValid=%b occupancy=%0d want 0/0", k, wbValid, occupancy);
            end
            n_cmp++; if ({inReady, occupancy, illegalOp} !== ctl_exp) begin
                n_fail++; $display("FAIL illegal_ctl k=%0d: got %b want %b", k, {inReady, occupancy, illegalOp}, ctl_exp);
            end
            advance();
        end
    endtask

    task automatic test_flush();
        int n_wb = 0;
        for (int k = 0; k < 9; k++) begin
            if (k < 3)       drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 3'(k + 1), TW'(k + 1), 1'b0);
            else if (k == 3) drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 3'b010, 4'd9, 1'b1);
            else             drive(1'b0, '0, '0, 3'b000, '0, 1'b0);
            n_cmp++; if ({wbValid, wbTag, wbData} !== wb_exp) begin
                n_fail++; $display("FAIL flush_wb k=%0d: got %b/%h/%h want %h", k, wbValid, wbTag, wbData, wb_exp);
            end
            n_cmp++; if ({inReady, occupancy, illegalOp} !== ctl_exp) begin
                n_fail++; $display("FAIL flush_ctl k=%0d: got %b want %b", k, {inReady, occupancy, illegalOp}, ctl_exp);
            end
            if (wbValid) begin
                n_wb++;
                $display("flush: wb tag=%0d data=%h", wbTag, wbData);
            end
            advance();
        end
        n_cmp++; if (n_wb !== 1) begin n_fail++; $display("FAIL flush_count: got %0d pulses want 1", n_wb); end
    endtask

    task automatic test_random();
        logic          v;
        logic          fl;
        logic [2:0]    op;
        for (int k = 0; k < 200; k++) begin
            v  = (k < 195) && ($urandom_range(0, 3) != 0);
            fl = (k < 195) && ($urandom_range(0, 24) == 0);
            op = 3'($urandom_range(0, 7));
            drive(v, {$urandom, $urandom}, {$urandom, $urandom}, op, TW'($urandom), fl);
            n_cmp++; if ({wbValid, wbTag, wbData} !== wb_exp) begin
                n_fail++; $display("FAIL rand_wb cyc=%0d: got %b/%h/%h want %h", cyc, wbValid, wbTag, wbData, wb_exp);
            end
            n_cmp++; if ({aluOper1, aluOper2, aluOpCode} !== alu_exp) begin
                n_fail++; $display("FAIL rand_alu cyc=%0d: got %h %h %b want %h", cyc, aluOper1, aluOper2, aluOpCode, alu_exp);
            end
            n_cmp++; if ({inReady, occupancy, illegalOp} !== ctl_exp) begin
                n_fail++; $display("FAIL rand_ctl cyc=%0d: got %b want %b", cyc, {inReady, occupancy, illegalOp}, ctl_exp);
            end
            if (wbValid) $display("rand: wb tag=%0d data=%h", wbTag, wbData);
            advance();
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 3'(k), TW'(k + 10), 1'b0);
            advance();
        end
        drive(1'b0, '0, '0, 3'b000, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({wbValid, wbTag, wbData, illegalOp, occupancy, aluOper1, aluOper2, aluOpCode} !== '0) begin
            n_fail++; $display("FAIL async_reset: got wb=%b/%h/%h occ=%0d alu=%b want all 0",
                               wbValid, wbTag, wbData, occupancy, aluOpCode);
        end
        n_cmp++; if (inReady !== 1'b1) begin n_fail++; $display("FAIL async_reset_ready: got %b want 1", inReady); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, '0, '0, 3'b000, '0, 1'b0);
            n_cmp++; if ({wbValid, wbTag, wbData} !== wb_exp) begin
                n_fail++; $display("FAIL post_reset_wb k=%0d: got %b/%h/%h want %h", k, wbValid, wbTag, wbData, wb_exp);
            end
            n_cmp++; if ({inReady, occupancy, illegalOp} !== ctl_exp) begin
                n_fail++; $display("FAIL post_reset_ctl k=%0d: got %b want %b", k, {inReady, occupancy, illegalOp}, ctl_exp);
            end
            advance();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        inValid  = 1'b0;
        inOper1  = '0;
        inOper2  = '0;
        inOpCode = '0;
        inTag    = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
